mux4_rr_arbiter: RTL and testbench

- Shares one 4:1 selector path between four requesters (a, b, c, d) using round-robin arbitration with bounded bursts.
- Drives the select pair s1/s0 to the downstream 4:1 mux and a one-hot grant back to the requesters.
- Registers the selected data as a valid-qualified output stream.
- Sits between the four source blocks and the shared mux/output consumer.

---
 rtl/mux4_rr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Shares one 4:1 select path between four requesters (a, b, c, d).
//   Round-robin arbitration with bounded bursts of up to MAX_BURST beats.
//   The winner drives the registered select pair s1/s0 and a one-hot grant.
//   Each beat copies the selected input into y and raises y_valid.
//
// Parameters
//   DW        data width of a, b, c, d and y
//   MAX_BURST maximum beats per grant, 1..15
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous reset, active-high
//   req[3:0] request bits (0=a, 1=b, 2=c, 3=d)
//   a,b,c,d  source data
//   gnt[3:0] registered one-hot grant (zero in IDLE)
//   s1,s0    registered mux select; the value is parked while idle
//   y        registered selected data
//   y_valid  y holds a beat taken on the previous edge
//   busy     high while a grant is active
//
// Build option
//   ARB_FIXED_PRIO_EN  when defined, the lowest-index request always wins
//                      and the round-robin pointer is not built.
//
// state | meaning
// IDLE  | no grant; arbitrate any pending request on the next edge
// GRANT | source {s1,s0} owns the path; one beat per edge while it requests

module mux4_rr_arbiter #(
  parameter int DW        = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [3:0]    gnt,
  output logic          s0,
  output logic          s1,
  output logic [DW-1:0] y,
  output logic          y_valid,
  output logic          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST);

  state_t        state, state_nxt;
  logic [1:0]    sel, sel_nxt;
  logic [3:0]    gnt_nxt;
  logic [3:0]    beat_cnt, beat_cnt_nxt;
  logic [DW-1:0] y_nxt;
  logic          y_valid_nxt;
  logic [DW-1:0] din;
  logic [1:0]    win;
  logic          rel;

  assign s1   = sel[1];
  assign s0   = sel[0];
  assign busy = (state == GRANT);

  always_comb begin
    case (sel)
      2'd0:    din = a;
      2'd1:    din = b;
      2'd2:    din = c;
      default: din = d;
    endcase
  end

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win = 2'd0;
    if (req[0])      win = 2'd0;
    else if (req[1]) win = 2'd1;
    else if (req[2]) win = 2'd2;
    else if (req[3]) win = 2'd3;
  end
`else
  logic [1:0] ptr;

  // Search ptr+1, ptr+2, ptr+3 (ptr+1 assigned last, so it has priority);
  // if none of those request, ptr itself must be the requester.
  always_comb begin
    win = ptr;
    for (int k = 3; k >= 1; k--) begin
      if (req[ptr + 2'(k)]) win = ptr + 2'(k);
    end
  end

  // ptr=3 after reset makes requester 0 the first in line.
  always_ff @(posedge clk) begin
    if (rst)                        ptr <= 2'd3;
    else if (state == GRANT && rel) ptr <= sel;
  end
`endif

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    sel_nxt      = sel;
    beat_cnt_nxt = beat_cnt;
    y_nxt        = y;
    y_valid_nxt  = 1'b0;
    rel          = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt = 4'b0000;
        if (req != 4'b0000) begin
          state_nxt    = GRANT;
          gnt_nxt      = 4'b0001 << win;
          sel_nxt      = win;
          beat_cnt_nxt = 4'd0;
        end
      end
      GRANT: begin
        if (req[sel]) begin
          y_nxt        = din;
          y_valid_nxt  = 1'b1;
          beat_cnt_nxt = beat_cnt + 4'd1;
          if (beat_cnt + 4'd1 == BURST_LAST) rel = 1'b1;
        end else begin
          rel = 1'b1;
        end
        if (rel) begin
          state_nxt    = IDLE;
          gnt_nxt      = 4'b0000;
          beat_cnt_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      beat_cnt <= 4'd0;
      y        <= '0;
      y_valid  <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      beat_cnt <= beat_cnt_nxt;
      y        <= y_nxt;
      y_valid  <= y_valid_nxt;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [DW-1:0] a, b, c, d;
  logic [3:0]    gnt;
  logic          s0, s1, y_valid, busy;
  logic [DW-1:0] y;

  mux4_rr_arbiter #(.DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .d(d),
    .gnt(gnt), .s0(s0), .s1(s1), .y(y), .y_valid(y_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the path, how many beats it has taken,
  // who was served last, and what the output registers must hold.
  int            m_owner = -1;
  int            m_beats = 0;
  int            m_last  = 3;
  int            m_sel   = 0;
  logic [DW-1:0] m_y     = '0;
  bit            m_yv    = 1'b0;

  function automatic int pick(input logic [3:0] r, input int last);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
`endif
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [DW-1:0] src [4];
    src = '{a, b, c, d};
    if (rst) begin
      m_owner = -1; m_beats = 0; m_last = 3; m_sel = 0; m_y = '0; m_yv = 1'b0;
    end else if (m_owner < 0) begin
      m_yv = 1'b0;
      if (req != 4'b0000) begin
        m_owner = pick(req, m_last);
        m_sel   = m_owner;
        m_beats = 0;
      end
    end else if (req[m_owner]) begin
      m_y  = src[m_owner];
      m_yv = 1'b1;
      m_beats++;
      if (m_beats == MB) begin
        m_last = m_owner; m_owner = -1; m_beats = 0;
      end
    end else begin
      m_yv = 1'b0;
      m_last = m_owner; m_owner = -1; m_beats = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_gnt",   gnt, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("m_sel",   {s1, s0}, m_sel);
      chk("m_yv",    y_valid, m_yv);
      chk("m_y",     y, m_y);
      chk("m_busy",  busy, (m_owner >= 0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] g;
    int exp_g [21];
    int pulses;
    rst = 1'b1; req = 4'b0000; a = '0; b = '0; c = '0; d = '0;
    step();
    cmp_en = 1'b1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_y", y, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Single requester: 4 beats, one gap, grant again.
    req = 4'b0001; a = 8'd1;
    step();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_sel", {s1, s0}, 2'b00);
    chk("t1_yv0", y_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_yv", y_valid, 1);
      chk("t1_y", y, 1);
    end
    chk("t1_gap", gnt, 4'b0000);
    step();
    chk("t1_regnt", gnt, 4'b0001);
    chk("t1_yv_gap", y_valid, 0);
    req = 4'b0000;

`ifndef ARB_FIXED_PRIO_EN
    // All requesting: strict rotation with one-cycle gaps.
    do_reset();
    exp_g = '{1,1,1,1,0, 2,2,2,2,0, 4,4,4,4,0, 8,8,8,8,0, 1};
    req = 4'b1111;
    for (int i = 0; i < 21; i++) begin
      step();
      chk("t2_gnt", gnt, exp_g[i]);
      if (exp_g[i] != 0) chk("t2_sel", {s1, s0}, (i / 5) % 4);
    end
    req = 4'b0000;
`else
    // Fixed priority: source 0 always wins while it requests.
    do_reset();
    exp_g = '{1,1,1,1,0, 1,1,1,1,0, 1,0,0,0,0, 0,0,0,0,0, 0};
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("fp_gnt", gnt, exp_g[i]);
    end
    req = 4'b1110;
    g = 4'b0000;
    for (int i = 0; i < 10 && g == 4'b0000; i++) begin
      step();
      g = gnt;
    end
    chk("fp_next", g, 4'b0010);
    req = 4'b0000;
`endif

    // Early drop after 2 beats, then pointer check.
    do_reset();
    step();
    req = 4'b0100; a = 8'd0; b = 8'd0; c = 8'd1; d = 8'd0;
    step();
    chk("t3_gnt", gnt, 4'b0100);
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (y_valid && y == 8'd1) pulses++;
    end
    req = 4'b0000;
    step();
    chk("t3_rel", gnt, 4'b0000);
    chk("t3_yv", y_valid, 0);
    chk("t3_pulses", pulses, 2);
    req = 4'b1111;
    step();
`ifndef ARB_FIXED_PRIO_EN
    chk("t3_next", gnt, 4'b1000);
`else
    chk("t3_next", gnt, 4'b0001);
`endif
    req = 4'b0000;

    // Reset during beat 2 of a source-1 burst.
    do_reset();
    req = 4'b0010; b = 8'h5a;
    step();
    chk("t4_gnt", gnt, 4'b0010);
    step();
    chk("t4_beat1", y, 8'h5a);
    rst = 1'b1;
    step();
    chk("t4_gnt0", gnt, 4'b0000);
    chk("t4_yv0", y_valid, 0);
    chk("t4_y0", y, 0);
    chk("t4_busy0", busy, 0);
    rst = 1'b0; req = 4'b1111;
    step();
    chk("t4_first", gnt, 4'b0001);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      a = DW'($urandom); b = DW'($urandom); c = DW'($urandom); d = DW'($urandom);
      step();
    end
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
